// File: rtl/mips_icache_if.sv
// Fetch-port and line-fill bus between MIPS_IF, the instruction cache and slow instruction memory.
// The master side is the IF/memory environment; the slave side is the cache.
interface mips_icache_if;
  logic         proc_read;
  logic         proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic [31:0]  proc_rdata;
  logic         proc_stall;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  modport master (
    output proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
    input  proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport slave (
    input  proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
    output proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mips_icache.sv
// Read-only direct-mapped instruction cache in front of MIPS_IF.
// Lines hold 4 words and are filled from memory in a single 128-bit transfer.
module mips_icache #(
  parameter int INDEX_BITS = 3
) (
  input logic          clk,
  input logic          rst_n,
  mips_icache_if.slave bus
);
  localparam int LINES    = 2 ** INDEX_BITS;
  localparam int TAG_BITS = 28 - INDEX_BITS;

  typedef enum logic {S_IDLE, S_ALLOC} state_t;

  state_t state, state_nx;

  logic [LINES-1:0]    valid;
  logic [TAG_BITS-1:0] tag_arr  [LINES];
  logic [127:0]        data_arr [LINES];
  logic [27:0]         miss_line;

  logic [TAG_BITS-1:0]   req_tag;
  logic [INDEX_BITS-1:0] req_idx;
  logic [1:0]            req_word;
  logic [127:0]          req_line;
  logic                  hit;
  logic                  latch_miss;
  logic                  fill;
  logic [INDEX_BITS-1:0] fill_idx;
  logic [TAG_BITS-1:0]   fill_tag;

  assign req_tag  = bus.proc_addr[29:INDEX_BITS+2];
  assign req_idx  = bus.proc_addr[INDEX_BITS+1:2];
  assign req_word = bus.proc_addr[1:0];
  assign req_line = data_arr[req_idx];
  assign hit      = valid[req_idx] && (tag_arr[req_idx] == req_tag);

  assign fill_idx = miss_line[INDEX_BITS-1:0];
  assign fill_tag = miss_line[27:INDEX_BITS];

  assign bus.mem_addr  = miss_line;
  assign bus.mem_write = 1'b0;
  assign bus.mem_wdata = '0;

  // Writes from IF never reach the cache; keep them observed for lint only.
  logic unused_inputs;
  assign unused_inputs = ^{bus.proc_write, bus.proc_wdata};

  always_comb begin
    state_nx       = state;
    bus.proc_stall = 1'b0;
    bus.proc_rdata = '0;
    bus.mem_read   = 1'b0;
    latch_miss     = 1'b0;
    fill           = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.proc_read) begin
          if (hit) begin
            bus.proc_rdata = req_line[{req_word, 5'd0} +: 32];
          end else begin
            bus.proc_stall = 1'b1;
            latch_miss     = 1'b1;
            state_nx       = S_ALLOC;
          end
        end
      end
      S_ALLOC: begin
        // Fill targets the latched line even if IF has redirected proc_addr.
        bus.proc_stall = 1'b1;
        bus.mem_read   = 1'b1;
        if (bus.mem_ready) begin
          fill     = 1'b1;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      valid     <= '0;
      miss_line <= '0;
    end else begin
      state <= state_nx;
      if (latch_miss) miss_line <= bus.proc_addr[29:2];
      if (fill) valid[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill) begin
      tag_arr[fill_idx]  <= fill_tag;
      data_arr[fill_idx] <= bus.mem_rdata;
    end
  end
endmodule

// File: tb/tb_mips_icache.sv
// Scoreboard bench for mips_icache: a 3-cycle-latency memory responder and
// per-scenario tasks that queue expected fetch data and compare on delivery.
module tb_mips_icache;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mips_icache_if bus ();

  mips_icache #(.INDEX_BITS(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int fills  = 0;
  bit stray_req = 1'b0;
  logic [31:0] exp_q[$];

  function automatic logic [127:0] line_data(input logic [27:0] line);
    logic [127:0] d;
    for (int w = 0; w < 4; w++)
      d[w*32 +: 32] = (32'h11111111 * (w + 1)) ^ {line, 4'h0};
    return d;
  endfunction

  function automatic logic [31:0] word_data(input logic [29:0] a);
    logic [127:0] d;
    d = line_data(a[29:2]);
    return d[{a[1:0], 5'd0} +: 32];
  endfunction

  // Memory model: mem_ready pulses on the 3rd consecutive cycle mem_read is seen.
  initial begin
    int cnt;
    cnt = 0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_ready) begin
        bus.mem_ready = 1'b0;
        cnt = 0;
      end else if (stray_req) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = {4{32'hdeadbeef}};
        stray_req = 1'b0;
      end else if (bus.mem_read) begin
        cnt++;
        if (cnt == 3) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = line_data(bus.mem_addr);
          fills++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic fetch(input logic [29:0] a, input bit exp_miss);
    int n;
    int f0;
    bit saw;
    logic [27:0] got_addr;
    logic [31:0] e;
    saw = 1'b0;
    got_addr = '0;
    f0 = fills;
    @(negedge clk);
    bus.proc_read = 1'b1;
    bus.proc_addr = a;
    exp_q.push_back(word_data(a));
    #1;
    checks++;
    if (bus.proc_stall !== exp_miss) begin
      errors++;
      $display("FAIL stall_first addr=%h got=%b exp=%b", a, bus.proc_stall, exp_miss);
    end
    if (!exp_miss) begin
      checks++;
      if (bus.mem_read !== 1'b0) begin
        errors++;
        $display("FAIL hit_mem_read addr=%h got=%b exp=0", a, bus.mem_read);
      end
    end
    n = 0;
    while (bus.proc_stall === 1'b1 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
      if (bus.mem_read === 1'b1 && !saw) begin
        saw = 1'b1;
        got_addr = bus.mem_addr;
      end
    end
    e = exp_q.pop_front();
    checks++;
    if (bus.proc_stall !== 1'b0) begin
      errors++;
      $display("FAIL fetch_timeout addr=%h stall=%b exp=0", a, bus.proc_stall);
    end else if (bus.proc_rdata !== e) begin
      errors++;
      $display("FAIL rdata addr=%h got=%h exp=%h", a, bus.proc_rdata, e);
    end
    if (exp_miss) begin
      checks++;
      if (!saw || got_addr !== a[29:2]) begin
        errors++;
        $display("FAIL miss_mem_addr addr=%h seen=%b got=%h exp=%h", a, saw, got_addr, a[29:2]);
      end
    end
    checks++;
    if (fills - f0 != (exp_miss ? 1 : 0)) begin
      errors++;
      $display("FAIL fill_count addr=%h got=%0d exp=%0d", a, fills - f0, exp_miss ? 1 : 0);
    end
  endtask

  task automatic test_reset();
    bus.proc_read  = 1'b0;
    bus.proc_write = 1'b0;
    bus.proc_addr  = '0;
    bus.proc_wdata = '0;
    rst_n = 1'b0;
    #12;
    checks++;
    if (bus.proc_stall !== 1'b0 || bus.mem_read !== 1'b0 || bus.proc_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs stall=%b mem_read=%b rdata=%h exp=0/0/0",
               bus.proc_stall, bus.mem_read, bus.proc_rdata);
    end
    checks++;
    if (bus.mem_write !== 1'b0 || bus.mem_wdata !== 128'h0) begin
      errors++;
      $display("FAIL reset_mem_write got=%b/%h exp=0/0", bus.mem_write, bus.mem_wdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_cold_fetch();
    fetch(30'h0, 1'b1);
  endtask

  task automatic test_same_line();
    fetch(30'h1, 1'b0);
    fetch(30'h2, 1'b0);
    fetch(30'h3, 1'b0);
  endtask

  task automatic test_conflict();
    fetch(30'h20, 1'b1);
    fetch(30'h21, 1'b0);
    fetch(30'h0, 1'b1);
  endtask

  task automatic test_redirect();
    int n;
    int f0;
    bit saw;
    logic [31:0] e;
    saw = 1'b0;
    f0 = fills;
    @(negedge clk);
    bus.proc_read = 1'b1;
    bus.proc_addr = 30'h4;
    #1;
    checks++;
    if (bus.proc_stall !== 1'b1) begin
      errors++;
      $display("FAIL redirect_stall got=%b exp=1", bus.proc_stall);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.mem_read !== 1'b1 || bus.mem_addr !== 28'h1) begin
      errors++;
      $display("FAIL redirect_first_req mem_read=%b mem_addr=%h exp=1/0000001", bus.mem_read, bus.mem_addr);
    end
    @(negedge clk);
    bus.proc_addr = 30'h40;
    exp_q.push_back(word_data(30'h40));
    #1;
    n = 0;
    while (bus.proc_stall === 1'b1 && n < 60) begin
      @(negedge clk);
      #1;
      n++;
      if (bus.mem_read === 1'b1 && bus.mem_addr === 28'h10) saw = 1'b1;
    end
    e = exp_q.pop_front();
    checks++;
    if (bus.proc_stall !== 1'b0 || bus.proc_rdata !== e) begin
      errors++;
      $display("FAIL redirect_rdata stall=%b got=%h exp=%h", bus.proc_stall, bus.proc_rdata, e);
    end
    checks++;
    if (!saw || fills - f0 != 2) begin
      errors++;
      $display("FAIL redirect_second_miss seen=%b fills=%0d exp=1/2", saw, fills - f0);
    end
    fetch(30'h4, 1'b0);
  endtask

  task automatic test_idle();
    fetch(30'h5, 1'b0);
    @(negedge clk);
    bus.proc_read = 1'b0;
    bus.proc_addr = 30'h3ff0_0000;
    #1;
    checks++;
    if (bus.proc_stall !== 1'b0 || bus.mem_read !== 1'b0 || bus.proc_rdata !== 32'h0) begin
      errors++;
      $display("FAIL idle_outputs stall=%b mem_read=%b rdata=%h exp=0/0/0",
               bus.proc_stall, bus.mem_read, bus.proc_rdata);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.mem_read !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_mem_read got=%b exp=0", bus.mem_read);
    end
    fetch(30'h6, 1'b0);
  endtask

  task automatic test_stray_ready();
    @(negedge clk);
    bus.proc_read = 1'b0;
    stray_req = 1'b1;
    repeat (3) @(negedge clk);
    fetch(30'h40, 1'b0);
    fetch(30'h7, 1'b0);
  endtask

  task automatic test_write_ignored();
    @(negedge clk);
    bus.proc_write = 1'b1;
    bus.proc_wdata = 32'hffffffff;
    fetch(30'h42, 1'b0);
    checks++;
    if (bus.mem_write !== 1'b0 || bus.mem_wdata !== 128'h0) begin
      errors++;
      $display("FAIL write_ignored mem_write=%b mem_wdata=%h exp=0/0", bus.mem_write, bus.mem_wdata);
    end
    bus.proc_write = 1'b0;
    bus.proc_wdata = '0;
    fetch(30'h42, 1'b0);
  endtask

  task automatic test_reset_mid_fill();
    @(negedge clk);
    bus.proc_read = 1'b1;
    bus.proc_addr = 30'h80;
    @(negedge clk);
    #1;
    checks++;
    if (bus.mem_read !== 1'b1) begin
      errors++;
      $display("FAIL midfill_req mem_read=%b exp=1", bus.mem_read);
    end
    #1;
    rst_n = 1'b0;
    bus.proc_read = 1'b0;
    #1;
    checks++;
    if (bus.mem_read !== 1'b0 || bus.proc_stall !== 1'b0) begin
      errors++;
      $display("FAIL midfill_abort mem_read=%b stall=%b exp=0/0", bus.mem_read, bus.proc_stall);
    end
    @(negedge clk);
    rst_n = 1'b1;
    fetch(30'h1, 1'b1);
    fetch(30'h80, 1'b1);
  endtask

  initial begin
    test_reset();
    test_cold_fetch();
    test_same_line();
    test_conflict();
    test_redirect();
    test_idle();
    test_stray_ready();
    test_write_ignored();
    test_reset_mid_fill();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
endmodule
